mm_iddmm_core_v2: RTL and testbench

//  Word-serial IDDMM Montgomery multiplier with a runtime operand length.

---
 rtl/mm_iddmm_core_v2.sv | 204 ++++++++++++++++++++
 tb/tb_mm_iddmm_core_v2.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_iddmm_core_v2.sv
// mm_iddmm_core_v2 -- word-serial IDDMM Montgomery multiplier.
//   RES = X*Y*R^-1 mod M, R = 2^(K*NW), NW (1..N) chosen per job.
//   Operand words go into X/Y/M word RAMs; A is the running accumulator,
//   D holds A-M, and the final select picks A or D for streaming.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   wr_en/wr_addr/wr_x/wr_y/wr_m operand word write (ignored while busy)
//   wr_m1                        -M^-1 mod 2^K, latched on a write to word 0
//   start/nw                     job start and active word count
//   abort                        synchronous return to IDLE
//   busy/err/done                status
//   res/res_valid/res_ready/res_last  LSW-first result stream
module mm_iddmm_core_v2 #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_x,
  input  logic [K-1:0]      wr_y,
  input  logic [K-1:0]      wr_m,
  input  logic [K-1:0]      wr_m1,
  input  logic              start,
  input  logic [ADDR_W:0]   nw,
  input  logic              abort,
  output logic              busy,
  output logic              err,
  output logic [K-1:0]      res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_QCALC, S_ROW, S_ROWEND, S_SUB, S_SEL, S_OUT
  } state_t;

  localparam logic [ADDR_W:0] NMAX = (ADDR_W+1)'(N);

  state_t            state;
  logic [K-1:0]      x_ram [N];
  logic [K-1:0]      y_ram [N];
  logic [K-1:0]      m_ram [N];
  logic [K-1:0]      a_lo  [N];   // A[0..NW-1]
  logic [K-1:0]      d_ram [N];   // A - M
  logic [K-1:0]      a_top;       // A[NW], only ever 0 or 1
  logic [K-1:0]      m1_r, q_r;
  logic [K+1:0]      c_r;         // row carry, t>>K of a 2K+2-bit sum
  logic              b_r, sel_a;
  logic [ADDR_W-1:0] i_r, j_r, last_r;

  logic              wr_ok, nw_ok, use_a;
  logic [K-1:0]      xj, yi, mj, aj, s0, q_next;
  logic [2*K-1:0]    xy, qm;
  logic [2*K+1:0]    t;
  logic [K:0]        dif;
  logic [K+2:0]      rs;
  logic [ADDR_W-1:0] jp1, jm1;

  always_comb begin
    wr_ok  = wr_en && (state == S_IDLE);
    nw_ok  = (nw != '0) && (nw <= NMAX);
    xj     = x_ram[j_r];
    yi     = y_ram[i_r];
    mj     = m_ram[j_r];
    aj     = a_lo[j_r];
    // only the low word matters for q, so K-bit arithmetic suffices
    s0     = a_lo[0] + x_ram[0] * yi;
    q_next = s0 * m1_r;
    xy     = {{K{1'b0}}, xj} * {{K{1'b0}}, yi};
    qm     = {{K{1'b0}}, q_r} * {{K{1'b0}}, mj};
    t      = {{(K+2){1'b0}}, aj} + {2'b00, xy} + {2'b00, qm} + {{K{1'b0}}, c_r};
    dif    = {1'b0, aj} - {1'b0, mj} - {{K{1'b0}}, b_r};
    rs     = {3'b000, a_top} + {1'b0, c_r};
    // borrow out of the low words with no top word means A < M
    use_a  = (a_top == '0) && b_r;
    jp1    = j_r + ADDR_W'(1);
    jm1    = j_r - ADDR_W'(1);
  end

  // Word storage and arithmetic; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      x_ram[wr_addr] <= wr_x;
      y_ram[wr_addr] <= wr_y;
      m_ram[wr_addr] <= wr_m;
    end
    case (state)
      S_INIT: begin
        for (int k = 0; k < N; k++) a_lo[k] <= '0;
        a_top <= '0;
        c_r   <= '0;
      end
      S_QCALC: begin
        q_r <= q_next;
        c_r <= '0;
      end
      S_ROW: begin
        c_r <= t[2*K+1:K];
        // word 0 of each row is zero by choice of q; results shift down one
        if (j_r != '0) a_lo[jm1] <= t[K-1:0];
      end
      S_ROWEND: begin
        a_lo[last_r] <= rs[K-1:0];
        a_top        <= K'(rs[K+2:K]);
        b_r          <= 1'b0;
      end
      S_SUB: begin
        d_ram[j_r] <= dif[K-1:0];
        b_r        <= dif[K];
      end
      S_SEL:   sel_a <= use_a;
      default: ;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      m1_r      <= '0;
      i_r       <= '0;
      j_r       <= '0;
      last_r    <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      if (wr_ok && wr_addr == '0) m1_r <= wr_m1;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            if (nw_ok) begin
              state  <= S_INIT;
              busy   <= 1'b1;
              i_r    <= '0;
              last_r <= ADDR_W'(nw - (ADDR_W+1)'(1));
            end else begin
              err <= 1'b1;
            end
          end
          S_INIT:  state <= S_QCALC;
          S_QCALC: begin
            j_r   <= '0;
            state <= S_ROW;
          end
          S_ROW: begin
            if (j_r == last_r) state <= S_ROWEND;
            else               j_r   <= jp1;
          end
          S_ROWEND: begin
            if (i_r == last_r) begin
              j_r   <= '0;
              state <= S_SUB;
            end else begin
              i_r   <= i_r + ADDR_W'(1);
              state <= S_QCALC;
            end
          end
          S_SUB: begin
            if (j_r == last_r) state <= S_SEL;
            else               j_r   <= jp1;
          end
          S_SEL: begin
            j_r       <= '0;
            res       <= use_a ? a_lo[0] : d_ram[0];
            res_valid <= 1'b1;
            res_last  <= (last_r == '0);
            state     <= S_OUT;
          end
          S_OUT: if (res_ready) begin
            if (res_last) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              j_r      <= jp1;
              res      <= sel_a ? a_lo[jp1] : d_ram[jp1];
              res_last <= (jp1 == last_r);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mm_iddmm_core_v2.sv
// Bench for mm_iddmm_core_v2 at K=8, N=4. Expected words come from a
// bit-serial Montgomery model and are queued when a job is launched.
module tb_mm_iddmm_core_v2;
  localparam int K = 8, N = 4, AW = 2;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic          wr_en = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [K-1:0]  wr_x = '0, wr_y = '0, wr_m = '0, wr_m1 = '0;
  logic          start = 0, abort = 0, res_ready = 0;
  logic [AW:0]   nw = '0;
  logic          busy, err, res_valid, res_last, done;
  logic [K-1:0]  res;

  mm_iddmm_core_v2 #(.K(K), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
    .start(start), .nw(nw), .abort(abort), .busy(busy), .err(err),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .res_last(res_last), .done(done)
  );

  int total = 0, bad = 0, done_cnt = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  typedef struct { logic [K-1:0] w; logic last; } exp_t;
  exp_t sb[$];

  typedef struct {
    int nw; logic [31:0] x, y, m; logic [7:0] m1; logic [31:0] r;
  } vec_t;
  vec_t tv[3];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mont(logic [31:0] x, y, m, int n);
    logic [63:0] v;
    v = (64'(x) * 64'(y)) % 64'(m);
    for (int i = 0; i < K*n; i++) v = v[0] ? (v + 64'(m)) >> 1 : v >> 1;
    return v[31:0];
  endfunction

  function automatic logic [7:0] neg_inv(logic [7:0] m);
    logic [7:0] c, p;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      p = c * m;
      if (p == 8'd1) return 8'd0 - c;
    end
    return 8'd0;
  endfunction

  // sink ready pattern
  initial forever begin
    @(posedge clk); #1;
    res_ready = (rdy_mode == 0) ? 1'b1 :
                (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // output monitor: scoreboard pop, hold-under-stall and no-bubble checks
  initial begin
    logic [K-1:0] p_res;
    logic p_last;
    bit p_stall, p_mid;
    exp_t e;
    p_res = '0; p_last = 0; p_stall = 0; p_mid = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst_n || abort) begin
        p_stall = 0; p_mid = 0;
      end else begin
        if (p_stall) begin
          chk("hold_valid", res_valid, 1);
          chk("hold_res", res, p_res);
          chk("hold_last", res_last, p_last);
        end
        if (p_mid) chk("no_bubble", res_valid, 1);
        p_stall = res_valid && !res_ready;
        p_res = res; p_last = res_last; p_mid = 0;
        if (res_valid && res_ready) begin
          if (sb.size() == 0) chk("unexpected_word", res_valid, 0);
          else begin
            e = sb.pop_front();
            chk("res", res, e.w);
            chk("res_last", res_last, e.last);
            p_mid = !e.last;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Writes words high-to-low; word 0 (with m1) shares its cycle with start.
  task automatic load_and_start(int n, logic [31:0] x, y, m, logic [7:0] m1);
    for (int w = n - 1; w >= 0; w--) begin
      wr_en = 1; wr_addr = AW'(w);
      wr_x = x[8*w +: 8]; wr_y = y[8*w +: 8]; wr_m = m[8*w +: 8]; wr_m1 = m1;
      if (w == 0) begin start = 1; nw = (AW+1)'(n); end
      tick();
    end
    wr_en = 0; start = 0;
  endtask

  task automatic push_exp(int n, logic [31:0] r);
    for (int w = 0; w < n; w++) sb.push_back('{w: r[8*w +: 8], last: (w == n - 1)});
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 500) begin tick(); g++; end
    chk("busy_drop", busy, 0);
    tick();
  endtask

  task automatic run_job(int n, logic [31:0] x, y, m, logic [7:0] m1, logic [31:0] r);
    int lat, d0;
    push_exp(n, r);
    d0 = done_cnt;
    load_and_start(n, x, y, m, m1);
    chk("busy_start", busy, 1);
    wait_valid(lat);
    chk("latency", lat, n*(n+2) + n + 2);
    wait_idle();
    chk("done_once", done_cnt - d0, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic rand_ops(int n, output logic [31:0] x, y, m, output logic [7:0] m1);
    logic [31:0] mask;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 1);
    m  = ($urandom & mask) | 32'd1;
    x  = $urandom % m;
    y  = $urandom % m;
    m1 = neg_inv(m[7:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y, m;
    logic [7:0] m1;
    int lat, d0;
    logic [AW:0] bad_nw[2];

    tv[0] = '{1, 32'h05, 32'h07, 32'hF1, 8'hEF, 32'hA3};
    tv[1] = '{1, 32'h01, 32'hE1, 32'hF1, 8'hEF, 32'h0F};
    tv[2] = '{1, 32'hF0, 32'hF0, 32'hF1, 8'hEF, 32'hE1};
    bad_nw[0] = 3'd0;
    bad_nw[1] = 3'd5;

    // reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_last", res_last, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    rst_n = 1;
    tick();

    // directed vectors
    rdy_mode = 0;
    for (int i = 0; i < 3; i++)
      run_job(tv[i].nw, tv[i].x, tv[i].y, tv[i].m, tv[i].m1, tv[i].r);

    // rejected starts
    foreach (bad_nw[i]) begin
      nw = bad_nw[i]; start = 1;
      tick();
      start = 0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      tick();
      chk("err_clear", err, 0);
      chk("err_idle", busy, 0);
    end

    // start and writes while busy are ignored
    rdy_mode = 2;
    push_exp(tv[0].nw, tv[0].r);
    d0 = done_cnt;
    load_and_start(tv[0].nw, tv[0].x, tv[0].y, tv[0].m, tv[0].m1);
    wr_en = 1; wr_addr = '0; wr_x = 8'hFF; wr_y = 8'hFF; wr_m = 8'h3; wr_m1 = 8'h0;
    tick();
    wr_en = 0;
    wait_valid(lat);
    chk("stall_valid", res_valid, 1);
    nw = 3'd5; start = 1;
    tick();
    start = 0;
    chk("busy_start_ignored_err", err, 0);
    chk("busy_start_ignored_busy", busy, 1);
    repeat (3) tick();
    rdy_mode = 0;
    wait_idle();
    chk("ignored_done", done_cnt - d0, 1);
    chk("ignored_sb", sb.size(), 0);

    // abort mid-ROW
    rand_ops(4, x, y, m, m1);
    load_and_start(4, x, y, m, m1);
    repeat (3) tick();
    d0 = done_cnt;
    abort = 1;
    tick();
    abort = 0;
    chk("abort_row_busy", busy, 0);
    chk("abort_row_valid", res_valid, 0);
    repeat (10) tick();
    chk("abort_row_nodone", done_cnt - d0, 0);

    // abort mid-OUT, then immediate NW=2 restart
    rdy_mode = 2;
    rand_ops(4, x, y, m, m1);
    load_and_start(4, x, y, m, m1);
    wait_valid(lat);
    chk("abort_out_reached", res_valid, 1);
    tick();
    d0 = done_cnt;
    abort = 1;
    tick();
    abort = 0;
    chk("abort_out_busy", busy, 0);
    chk("abort_out_valid", res_valid, 0);
    chk("abort_out_nodone", done_cnt - d0, 0);
    rdy_mode = 1;
    rand_ops(2, x, y, m, m1);
    run_job(2, x, y, m, m1, mont(x, y, m, 2));

    // random NW=4 jobs with throttled sink
    rdy_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      rand_ops(4, x, y, m, m1);
      run_job(4, x, y, m, m1, mont(x, y, m, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
